// File: rtl/prbs_pkg.sv
// prbs_pkg: PRBS-16 (x^16+x^15+1) definitions shared by the generator and checker ends
package prbs_pkg;
   localparam int PRBS_LEN = 16;
   localparam int TAP_A = 15;
   localparam int TAP_B = 14;
   typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;
   function automatic logic prbs_next(input logic [PRBS_LEN-1:0] h);
      return h[TAP_A] ^ h[TAP_B];
   endfunction
endpackage

// File: rtl/prbs_chk_loss_mon.sv
// prbs_chk_loss_mon: counts errors in non-overlapping blocks of LOSS_WIN steps, pulses loss at LOSS_THRESH
module prbs_chk_loss_mon #(
   parameter int LOSS_WIN = 64,
   parameter int LOSS_THRESH = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic step,
   input  logic err,
   input  logic restart,
   output logic loss
);
   localparam int BW = $clog2(LOSS_WIN + 1);
   localparam int EW = $clog2(LOSS_THRESH + 1);
   logic [BW-1:0] blk;
   logic [EW-1:0] errs;
   logic last;
   assign last = blk == BW'(LOSS_WIN - 1);
   assign loss = step && err && errs == EW'(LOSS_THRESH - 1);
   // block position and error tally, both cleared at each block boundary or restart
   always_ff @(posedge clk)
      if (rst || restart) begin
         blk <= '0;
         errs <= '0;
      end else if (step) begin
         blk <= last ? '0 : blk + BW'(1);
         errs <= last ? '0 : errs + EW'(err);
      end
endmodule

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising PRBS-16 checker with bit/error counters; PRBS_CHK_STICKY_LOSS_EN enables sticky lock_lost
module prbs_checker
   import prbs_pkg::*;
#(
   parameter int CNT_W = 32,
   parameter int LOCK_THRESH = 32,
   parameter int LOSS_WIN = 64,
   parameter int LOSS_THRESH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rx_bit,
   input  logic             rx_valid,
   input  logic             clear,
   output logic             locked,
   output logic             err_flag,
   output logic [CNT_W-1:0] bit_count,
   output logic [CNT_W-1:0] err_count,
   output logic             lock_lost
);
   localparam int MW = $clog2((LOCK_THRESH > PRBS_LEN ? LOCK_THRESH : PRBS_LEN) + 1);
   state_t state;
   logic [PRBS_LEN-1:0] h;
   logic [MW-1:0] cnt;
   logic e, miss, step, loss, fill_done, match_done;
   assign e = prbs_next(h);
   assign miss = rx_bit != e;
   assign step = rx_valid && state == LOCKED;
   assign fill_done = cnt == MW'(PRBS_LEN - 1);
   assign match_done = cnt == MW'(LOCK_THRESH - 1);

   prbs_chk_loss_mon #(.LOSS_WIN(LOSS_WIN), .LOSS_THRESH(LOSS_THRESH)) u_loss (
      .clk(clk),
      .rst(rst),
      .step(step),
      .err(miss),
      .restart(state != LOCKED),
      .loss(loss)
   );

   // hunt/verify/lock sequencing; in LOCKED the predicted bit is fed back so errors do not propagate
   always_ff @(posedge clk)
      if (rst) begin
         state <= HUNT;
         h <= '0;
         cnt <= '0;
         locked <= 1'b0;
         err_flag <= 1'b0;
      end else begin
         err_flag <= step && miss;
         if (rx_valid)
            case (state)
               HUNT: begin
                  h <= {h[PRBS_LEN-2:0], rx_bit};
                  cnt <= fill_done ? '0 : cnt + MW'(1);
                  if (fill_done) state <= VERIFY;
               end
               VERIFY: begin
                  h <= {h[PRBS_LEN-2:0], rx_bit};
                  cnt <= (miss || match_done) ? '0 : cnt + MW'(1);
                  if (miss) state <= HUNT;
                  else if (match_done) begin
                     state <= LOCKED;
                     locked <= 1'b1;
                  end
               end
               LOCKED: begin
                  h <= {h[PRBS_LEN-2:0], e};
                  if (loss) begin
                     state <= HUNT;
                     locked <= 1'b0;
                  end
               end
               default: state <= HUNT;
            endcase
      end

   // counters advance only on locked valid bits and freeze together once bit_count saturates
   always_ff @(posedge clk)
      if (rst || clear) begin
         bit_count <= '0;
         err_count <= '0;
      end else if (step && !(&bit_count)) begin
         bit_count <= bit_count + CNT_W'(1);
         err_count <= err_count + CNT_W'(miss);
      end

`ifdef PRBS_CHK_STICKY_LOSS_EN
   // remembers any drop out of LOCKED until cleared; a new drop beats a same-cycle clear
   always_ff @(posedge clk)
      if (rst) lock_lost <= 1'b0;
      else if (step && loss) lock_lost <= 1'b1;
      else if (clear) lock_lost <= 1'b0;
`else
   assign lock_lost = 1'b0;
`endif
endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: randomized PRBS stream against a queue-based reference model with a scoreboard monitor
module tb_prbs_checker;
   localparam int LOCK = 32;
   localparam int WIN = 64;
   localparam int THR = 8;
`ifdef PRBS_CHK_STICKY_LOSS_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif
   logic clk = 0, rst = 1, rx_bit = 0, rx_valid = 0, clear = 0;
   logic locked, err_flag, lock_lost, locked8, err_flag8, lock_lost8;
   logic [31:0] bit_count, err_count;
   logic [7:0] bit_count8, err_count8;

   prbs_checker dut (.clk(clk), .rst(rst), .rx_bit(rx_bit), .rx_valid(rx_valid), .clear(clear),
      .locked(locked), .err_flag(err_flag), .bit_count(bit_count), .err_count(err_count), .lock_lost(lock_lost));
   prbs_checker #(.CNT_W(8)) dut8 (.clk(clk), .rst(rst), .rx_bit(rx_bit), .rx_valid(rx_valid), .clear(clear),
      .locked(locked8), .err_flag(err_flag8), .bit_count(bit_count8), .err_count(err_count8), .lock_lost(lock_lost8));

   always #5 clk = ~clk;

   typedef struct {bit locked, flag, lost; logic [31:0] bc, ec; logic [7:0] bc8, ec8;} exp_t;
   exp_t sb[$];
   int tests = 0, fails = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: mode 0 hunting, 1 verifying, 2 locked; history is the last 16 bits, oldest first
   int m_mode, m_n, m_blk, m_errs;
   bit m_hist[$];
   int unsigned m_bc, m_ec, m_bc8, m_ec8;
   bit m_flag, m_lost;

   task automatic model(input bit r, input bit v, input bit b, input bit c);
      exp_t x;
      bit e, err;
      if (r) begin
         m_mode = 0; m_n = 0; m_blk = 0; m_errs = 0;
         m_hist = {};
         repeat (16) m_hist.push_back(1'b0);
         m_bc = 0; m_ec = 0; m_bc8 = 0; m_ec8 = 0; m_flag = 0; m_lost = 0;
      end else begin
         m_flag = 0;
         if (c) begin
            m_bc = 0; m_ec = 0; m_bc8 = 0; m_ec8 = 0; m_lost = 0;
         end
         if (v) begin
            e = m_hist[0] ^ m_hist[1];
            err = b != e;
            if (m_mode == 0) begin
               m_hist.push_back(b);
               m_n++;
               if (m_n == 16) begin m_mode = 1; m_n = 0; end
            end else if (m_mode == 1) begin
               m_hist.push_back(b);
               if (err) begin m_mode = 0; m_n = 0; end
               else begin
                  m_n++;
                  if (m_n == LOCK) begin m_mode = 2; m_n = 0; m_blk = 0; m_errs = 0; end
               end
            end else begin
               m_hist.push_back(e);
               m_flag = err;
               if (!c) begin
                  if (m_bc != 32'hFFFF_FFFF) begin m_bc++; m_ec += err; end
                  if (m_bc8 != 255) begin m_bc8++; m_ec8 += err; end
               end
               m_blk++;
               m_errs += err;
               if (m_errs == THR) begin
                  m_mode = 0; m_n = 0;
                  if (STICKY) m_lost = 1;
               end else if (m_blk == WIN) begin
                  m_blk = 0; m_errs = 0;
               end
            end
            void'(m_hist.pop_front());
         end
      end
      x.locked = m_mode == 2; x.flag = m_flag; x.lost = m_lost;
      x.bc = m_bc; x.ec = m_ec; x.bc8 = m_bc8[7:0]; x.ec8 = m_ec8[7:0];
      sb.push_back(x);
   endtask

   task automatic send(input bit r, input bit v, input bit b, input bit c);
      @(negedge clk);
      rst = r; rx_valid = v; rx_bit = b; clear = c;
      model(r, v, b, c);
   endtask

   // generator: seed of sixteen ones, then b[n] = b[n-15] ^ b[n-16]
   bit g[$];
   function automatic bit next_gen();
      bit nb;
      nb = g.size() < 16 ? 1'b1 : g[g.size()-15] ^ g[g.size()-16];
      g.push_back(nb);
      if (g.size() > 32) void'(g.pop_front());
      return nb;
   endfunction

   task automatic gen_bits(input int n, input int flip = 0, input bit inv_all = 0);
      for (int k = 1; k <= n; k++) begin
         while ($urandom_range(0, 3) == 0) send(0, 0, 1'($urandom), 0);
         send(0, 1, next_gen() ^ (k == flip) ^ inv_all, 0);
      end
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         exp_t x;
         x = sb.pop_front();
         chk("locked", locked, x.locked);
         chk("err_flag", err_flag, x.flag);
         chk("bit_count", bit_count, x.bc);
         chk("err_count", err_count, x.ec);
         chk("lock_lost", lock_lost, x.lost);
         chk("bit_count8", bit_count8, x.bc8);
         chk("err_count8", err_count8, x.ec8);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      repeat (3) send(1, 0, 0, 0);
      // idle after reset: nothing may move
      repeat (100) send(0, 0, 1'($urandom), 0);
      settle();
      chk("idle_locked", locked, 0);
      chk("idle_bit_count", bit_count, 0);
      // clean stream: lock after 48 valid bits
      gen_bits(47);
      settle();
      chk("locked_at_47", locked, 0);
      gen_bits(1);
      settle();
      chk("locked_at_48", locked, 1);
      gen_bits(952);
      settle();
      chk("bit_count_1000", bit_count, 952);
      chk("err_count_1000", err_count, 0);
      chk("bit_count8_sat", bit_count8, 255);
      // single error: one pulse, lock held
      gen_bits(99);
      gen_bits(1, 1);
      settle();
      chk("single_err_flag", err_flag, 1);
      chk("single_err_count", err_count, 1);
      chk("single_err_locked", locked, 1);
      chk("err_count8_frozen", err_count8, 0);
      chk("bit_count8_frozen", bit_count8, 255);
      // clear together with a valid bit while locked
      send(0, 1, next_gen(), 1);
      settle();
      chk("clear_bit_count", bit_count, 0);
      chk("clear_err_count", err_count, 0);
      chk("clear_locked", locked, 1);
      // eight errors inside one block force loss of lock
      while (m_blk != 0) gen_bits(1);
      gen_bits(8, 0, 1);
      settle();
      chk("loss_locked", locked, 0);
      chk("loss_err_count", err_count, 8);
      chk("loss_lock_lost", lock_lost, STICKY);
      gen_bits(47);
      settle();
      chk("relock_at_47", locked, 0);
      gen_bits(1);
      settle();
      chk("relock_at_48", locked, 1);
      // reset mid-operation, then a verify-phase error delays lock by 26 bits
      repeat (2) send(1, 1, 1'($urandom), 0);
      settle();
      chk("rst_locked", locked, 0);
      chk("rst_bit_count", bit_count, 0);
      chk("rst_lock_lost", lock_lost, 0);
      gen_bits(73, 26);
      settle();
      chk("verify_err_at_73", locked, 0);
      gen_bits(1);
      settle();
      chk("verify_err_at_74", locked, 1);
      // random traffic: error-rate bursts, gaps, clears and rare resets
      for (int i = 0; i < 4000; i++) begin
         int rate;
         rate = ((i / 400) % 2) ? 12 : 1;
         if ($urandom_range(0, 999) == 0) send(1, 0, 0, 0);
         else send(0, $urandom_range(0, 4) != 0, next_gen() ^ ($urandom_range(0, 99) < rate),
                   $urandom_range(0, 199) == 0);
      end
      repeat (4) send(0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #2;
      chk("scoreboard_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
